// File: rtl/transmissor_pkg.sv
// Shared definitions for the 8-bit serial transmitter: FSM state encoding,
// frame geometry and the idle level of the serial line.
package transmissor_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int   DATA_BITS     = 8;
  localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/transmissor_serial_8bits_contador_baud.sv
// Bit-time counter for the serial transmitter. Counts 0..CLKS_PER_BIT-1 and
// wraps at each bit boundary; tick is high on the last cycle of a bit time.
// With CLKS_PER_BIT=1 the counter stays at 0 and tick is high every cycle.
module contador_baud #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Bit-time counter: held at zero while cleared, wraps after LAST.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/transmissor_serial_8bits.sv
// UART-style transmitter draining the result register off-chip:
// start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Optional feature: define PARITY_EN to insert the even-parity bit
// (11 bit times per frame instead of 10).
//
// Handshake: a byte on d is accepted on a rising edge where
// load_valid && load_ready; load_ready is high only in IDLE, so offers made
// while a frame is in progress are ignored and nothing is queued.
module transmissor_serial_8bits
  import transmissor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] d,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t  state, next_state;
  logic [7:0] shift_reg;
  logic [2:0] bit_idx;
  logic       done_q;
  logic       tick;
  logic       accept;
`ifdef PARITY_EN
  logic       parity_q;
`endif

  assign accept = load_valid && (state == IDLE);

  contador_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_contador_baud (
    .clk   (clk),
    .reset (reset),
    .clear (state == IDLE),
    .tick  (tick)
  );

  // State register plus datapath: latch byte on accept, shift per data bit,
  // raise done for the first idle cycle after the stop bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      done_q    <= 1'b0;
`ifdef PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state  <= next_state;
      done_q <= (state == STOP) && tick;
      if (accept) begin
        shift_reg <= d;
        bit_idx   <= '0;
`ifdef PARITY_EN
        parity_q  <= ^d;
`endif
      end else if ((state == DATA) && tick) begin
        shift_reg <= shift_reg >> 1;
        bit_idx   <= bit_idx + 3'd1;
      end
    end
  end

  // Next-state and line/status outputs, decoded from the current state.
  always_comb begin
    next_state = state;
    tx         = TX_IDLE_LEVEL;
    busy       = 1'b1;
    load_ready = 1'b0;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        load_ready = 1'b1;
        if (load_valid) next_state = START;
      end
      START: begin
        tx = 1'b0;
        if (tick) next_state = DATA;
      end
      DATA: begin
        tx = shift_reg[0];
        if (tick && (bit_idx == LAST_BIT)) begin
`ifdef PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        tx = parity_q;
        if (tick) next_state = STOP;
      end
`endif
      STOP: begin
        tx = TX_IDLE_LEVEL;
        if (tick) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign done      = done_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_transmissor_serial_8bits.sv
// Self-checking bench for transmissor_serial_8bits. A frame model builds the
// expected per-cycle {tx, busy, done, load_ready} trace from the frame rules
// and a scoreboard queue compares it against the DUT at each falling edge.
module tb_transmissor_serial_8bits;
  import transmissor_pkg::*;

  localparam int CPB = 4;
`ifdef PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [7:0] d = 8'h00;
  logic       tx, busy, done;
  logic [2:0] state_dbg;

  logic [3:0] exp_q[$];
  logic [7:0] burst[4];
  int         n_cmp = 0;
  int         n_err = 0;

  transmissor_serial_8bits #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .d          (d),
    .tx         (tx),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] obs();
    return {tx, busy, done, load_ready};
  endfunction

  // Reference model: frame bit list -> per-cycle expected vectors.
  task automatic model_frame(input logic [7:0] b);
    logic bits[NBITS];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef PARITY_EN
    bits[9] = ^b;
`endif
    bits[NBITS-1] = 1'b1;
    for (int k = 0; k < NBITS; k++)
      for (int c = 0; c < CPB; c++) exp_q.push_back({bits[k], 1'b1, 1'b0, 1'b0});
    exp_q.push_back(4'b1011);  // done cycle: idle high, done, ready
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq(tag, 32'(obs()), 32'(4'b1001));
    end
  endtask

  // Driver: sends burst[0..n-1] back to back; noise 0=quiet, 1=random
  // d/load_valid mid-frame, 2=d=FF with load_valid held high mid-frame.
  task automatic run_burst(input int n, input int noise);
    logic [3:0] e;
    @(negedge clk);
    check_eq("ready_pre", 32'(load_ready), 32'd1);
    d = burst[0];
    load_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      model_frame(burst[i]);
      @(posedge clk);
      while (exp_q.size() > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq($sformatf("trace_b%0d", i), 32'(obs()), 32'(e));
        if (exp_q.size() == 0) begin
          if (i + 1 < n) begin
            d = burst[i+1];
            load_valid = 1'b1;
          end else begin
            load_valid = 1'b0;
          end
        end else if (noise == 1) begin
          d = 8'($urandom);
          load_valid = 1'($urandom_range(0, 1));
        end else if (noise == 2) begin
          d = 8'hFF;
          load_valid = 1'b1;
        end else begin
          d = 8'($urandom);
          load_valid = 1'b0;
        end
      end
    end
  endtask

  initial begin
    // Reset, then idle
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_outputs", 32'(obs()), 32'(4'b1001));
    check_eq("rst_state", 32'(state_dbg), 32'(IDLE));
    reset = 1'b0;
    idle_check("idle_after_rst", 20);

    // Basic frames (A5 then 07 exercises both parity values)
    burst[0] = 8'hA5; run_burst(1, 0);
    burst[0] = 8'h07; run_burst(1, 0);
    idle_check("idle_gap", 3);

    // Back-to-back: second byte offered in the done cycle
    burst[0] = 8'h3C; burst[1] = 8'hC3; run_burst(2, 0);
    idle_check("idle_after_b2b", 3);

    // Ignore while busy: FF offered throughout a 00 frame
    burst[0] = 8'h00; run_burst(1, 2);
    idle_check("no_second_frame", 2 * CPB);

    // Reset mid-frame during data bit 3 (bit time index 4)
    burst[0] = 8'h5A;
    @(negedge clk);
    d = burst[0];
    load_valid = 1'b1;
    model_frame(burst[0]);
    @(posedge clk);
    for (int c = 0; c < 4 * CPB + 2; c++) begin
      @(negedge clk);
      load_valid = 1'b0;
      check_eq("pre_abort", 32'(obs()), 32'(exp_q.pop_front()));
    end
    exp_q.delete();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_outputs", 32'(obs()), 32'(4'b1001));
    reset = 1'b0;
    idle_check("abort_no_done", NBITS * CPB);
    burst[0] = 8'h96; run_burst(1, 0);

    // Randomized bursts
    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) burst[i] = 8'($urandom);
      run_burst(n, $urandom_range(0, 1));
      idle_check("idle_rand", $urandom_range(1, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
